// File: rtl/data_mem.sv
`timescale 1ns/100ps
// data_mem: single-port word RAM with a registered read port, write-first collisions and an out-of-range guard.
// Optional macro DMEM_ZERO_INIT_EN adds a post-reset sweep that zeroes every word, one per clock.
module data_mem #(
    parameter int B = 16,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Wr,
    input  logic         Rd,
    input  logic [B-1:0] Addr,
    input  logic [B-1:0] In_Data,
    output logic [B-1:0] Out_Data,
    output logic         addr_err,
    output logic         ready
);
    localparam int DEPTH = 2**W;

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] idx;
    logic         in_range;
    logic         acc_wr;
    logic         acc_rd;
    logic [B-1:0] rd_data_d, rd_data_q;
    logic         addr_err_d, addr_err_q;

    assign idx      = Addr[W-1:0];
    assign in_range = (Addr[B-1:W] == '0);
    assign acc_wr   = ready & Wr;
    assign acc_rd   = ready & Rd;

`ifdef DMEM_ZERO_INIT_EN
    logic [W-1:0] clr_cnt_q;
    logic         sweep_q;

    // Sweep restarts from word 0 whenever reset is asserted; accesses are blocked until it ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
            sweep_q   <= 1'b1;
        end else if (sweep_q) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1)
                sweep_q <= 1'b0;
        end
    end

    assign ready = ~sweep_q;

    always_ff @(posedge clk) begin
        if (sweep_q)
            mem[clr_cnt_q] <= '0;
        else if (acc_wr && in_range)
            mem[idx] <= In_Data;
    end
`else
    assign ready = 1'b1;

    always_ff @(posedge clk) begin
        if (acc_wr && in_range)
            mem[idx] <= In_Data;
    end
`endif

    // Out-of-range reads return zero; a same-edge write forwards its data (write-first).
    always_comb begin
        rd_data_d  = rd_data_q;
        addr_err_d = addr_err_q;
        if (acc_wr || acc_rd)
            addr_err_d = ~in_range;
        if (acc_rd) begin
            if (!in_range)
                rd_data_d = '0;
            else if (acc_wr)
                rd_data_d = In_Data;
            else
                rd_data_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign Out_Data = rd_data_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem.sv
`timescale 1ns/100ps
// tb_data_mem: directed + randomized accesses checked against an array-based reference model.
module tb_data_mem;
    localparam int B     = 16;
    localparam int W     = 11;
    localparam int DEPTH = 2**W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         Wr = 1'b0;
    logic         Rd = 1'b0;
    logic [B-1:0] Addr = '0;
    logic [B-1:0] In_Data = '0;
    logic [B-1:0] Out_Data;
    logic         addr_err;
    logic         ready;

    data_mem #(.B(B), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Wr       (Wr),
        .Rd       (Rd),
        .Addr     (Addr),
        .In_Data  (In_Data),
        .Out_Data (Out_Data),
        .addr_err (addr_err),
        .ready    (ready)
    );

    always #1 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference state: word contents plus whether each word has a defined value.
    logic [B-1:0] m_mem [DEPTH];
    bit           m_vld [DEPTH];
    logic [B-1:0] e_out;
    bit           e_known;
    bit           e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_out   = '0;
        e_known = 1'b1;
        e_err   = 1'b0;
`ifdef DMEM_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b1;
        end
`endif
    endtask

    // Waits for ready while hammering the ports; none of it may reach the array or outputs.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 5000) begin
            Wr      = 1'($urandom);
            Rd      = 1'($urandom);
            Addr    = 16'($urandom_range(0, DEPTH-1));
            In_Data = 16'($urandom | 1);
            @(negedge clk);
            n++;
        end
        Wr = 1'b0;
        Rd = 1'b0;
        chk("ready_wait", 32'(ready), 32'd1);
`ifdef DMEM_ZERO_INIT_EN
        chk("sweep_len", 32'(n), 32'(DEPTH));
`endif
        chk("hold_out_after_rst", 32'(Out_Data), 32'(e_out));
        chk("hold_err_after_rst", 32'(addr_err), 32'(e_err));
    endtask

    task automatic op(input bit wr, input bit rd, input logic [B-1:0] a, input logic [B-1:0] d);
        bit inr;
        int i;
        Wr      = wr;
        Rd      = rd;
        Addr    = a;
        In_Data = d;
        @(negedge clk);
        inr = ((int'(a) >> W) == 0);
        i   = int'(a) % DEPTH;
        if (wr || rd)
            e_err = !inr;
        if (rd) begin
            if (!inr) begin
                e_out = '0; e_known = 1'b1;
            end else if (wr) begin
                e_out = d; e_known = 1'b1;
            end else begin
                e_out = m_mem[i]; e_known = m_vld[i];
            end
        end
        if (wr && inr) begin
            m_mem[i] = d;
            m_vld[i] = 1'b1;
        end
        if (e_known)
            chk($sformatf("out@%h", a), 32'(Out_Data), 32'(e_out));
        chk($sformatf("err@%h", a), 32'(addr_err), 32'(e_err));
        chk("ready", 32'(ready), 32'd1);
        Wr = 1'b0;
        Rd = 1'b0;
    endtask

    initial begin
        logic [B-1:0] a;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        model_reset();

        #0.2 rst_n = 1'b0;
        #0.2;
        chk("rst_out", 32'(Out_Data), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();

        // Write/read-back, hold, collision, range check.
        op(1, 0, 16'h0002, 16'h0F0F);
        op(1, 0, 16'h0002, 16'h0F0F);
        op(0, 0, 16'h0002, 16'h0000);
        op(0, 1, 16'h0002, 16'h0000);
        op(0, 0, 16'h0005, 16'h0000);
        op(1, 1, 16'h0003, 16'hA5A5);
        op(0, 1, 16'h0003, 16'h0000);
        op(1, 0, 16'h0802, 16'h1234);
        op(0, 0, 16'h0002, 16'h0000);
        op(0, 1, 16'h0002, 16'h0000);
        op(0, 1, 16'h0802, 16'h0000);
        op(0, 1, 16'hF7FF, 16'hFFFF);

        // Give every word in a small window a defined value, then hit it randomly.
        for (int i = 0; i < 16; i++) op(1, 0, 16'(i), 16'($urandom));
        for (int n = 0; n < 400; n++) begin
            a = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a[15:11] = 5'($urandom_range(1, 31));
            op(1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        // Reset mid-run between edges, with non-zero outputs to be cleared.
        op(1, 0, 16'h0002, 16'h0F0F);
        op(0, 1, 16'h0002, 16'h0000);
        op(1, 0, 16'h0803, 16'h5555);
        @(posedge clk);
        #0.4 rst_n = 1'b0;
        #0.2;
        chk("midrst_out", 32'(Out_Data), 32'd0);
        chk("midrst_err", 32'(addr_err), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        op(0, 1, 16'h0002, 16'h0000);
        op(0, 1, 16'h0000, 16'h0000);
        op(0, 1, 16'h07FF, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
